// File: rtl/fsk_pkg.sv
// Shared state encoding, default geometry and saturating counter helper
// for the FSK link controller.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } fsk_state_e;

  localparam int FSK_WORD_W  = 16;
  localparam int FSK_BIT_DIV = 16;
  localparam int ERR_CNT_W   = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_inc_sat(input logic [ERR_CNT_W-1:0] cnt);
    logic [ERR_CNT_W-1:0] res;
    if (cnt == {ERR_CNT_W{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + ERR_CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Bit-period timer: divides sysclk into bit periods and counts bits,
// flagging the bit boundary, the mid-bit sample point and the last bit.
module fsk_bit_timer
  import fsk_pkg::*;
#(
  parameter int WORD_W    = FSK_WORD_W,
  parameter int BIT_DIV   = FSK_BIT_DIV,
  parameter int RX_SAMPLE = 8,
  parameter int CNT_W     = 5
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  output logic             bit_tick,
  output logic             sample_tick,
  output logic             last_bit,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = $clog2(BIT_DIV);

  logic [DIV_W-1:0] div_cnt_r;
  logic [CNT_W-1:0] bit_cnt_r;

  // Divider and bit counter; clear has priority over run.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (run) begin
      if (div_cnt_r == DIV_W'(BIT_DIV - 1)) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end
  end

  assign bit_tick    = run && (div_cnt_r == DIV_W'(BIT_DIV - 1));
  assign sample_tick = run && (div_cnt_r == DIV_W'(RX_SAMPLE));
  assign last_bit    = (bit_cnt_r == CNT_W'(WORD_W - 1));
  assign bit_cnt     = bit_cnt_r;

endmodule

// File: rtl/fsk_link_ctrl.sv
// FSK frame sequencer: accepts a word, shifts it out MSB-first, samples the
// demodulated stream mid-bit and reports the received word and error count.
module fsk_link_ctrl
  import fsk_pkg::*;
#(
  parameter int WORD_W     = FSK_WORD_W,
  parameter int BIT_DIV    = FSK_BIT_DIV,
  parameter int RX_SAMPLE  = 8,
  parameter int GUARD_BITS = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 tx_bit,
  output logic                 trans_enable,
  input  logic                 rx_bit,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // The bit counter is reused to count guard periods, so size it for both.
  localparam int CNT_MAX    = (WORD_W > GUARD_BITS) ? WORD_W : GUARD_BITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int GUARD_LAST = (GUARD_BITS > 0) ? (GUARD_BITS - 1) : 0;

  fsk_state_e       state_r;
  logic [WORD_W-1:0] tx_shift_r;
  logic [WORD_W-1:0] tx_ref_r;
  logic [WORD_W-1:0] rx_shift_r;

  logic             bit_tick_s;
  logic             sample_tick_s;
  logic             last_bit_s;
  logic [CNT_W-1:0] bit_cnt_s;
  logic             run_s;
  logic             clear_s;
  logic             frame_end_s;
  logic             guard_end_s;

  assign run_s       = (state_r == SEND) || (state_r == GUARD);
  assign frame_end_s = (state_r == SEND) && bit_tick_s && last_bit_s;
  assign guard_end_s = (state_r == GUARD) && bit_tick_s && (bit_cnt_s == CNT_W'(GUARD_LAST));
  assign clear_s     = (state_r == IDLE) || frame_end_s;

  fsk_bit_timer #(
    .WORD_W    (WORD_W),
    .BIT_DIV   (BIT_DIV),
    .RX_SAMPLE (RX_SAMPLE),
    .CNT_W     (CNT_W)
  ) u_timer (
    .sysclk      (sysclk),
    .reset       (reset),
    .clear       (clear_s),
    .run         (run_s),
    .bit_tick    (bit_tick_s),
    .sample_tick (sample_tick_s),
    .last_bit    (last_bit_s),
    .bit_cnt     (bit_cnt_s)
  );

  // Frame FSM with shift registers and all registered outputs.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_r      <= IDLE;
      tx_shift_r   <= {WORD_W{1'b0}};
      tx_ref_r     <= {WORD_W{1'b0}};
      rx_shift_r   <= {WORD_W{1'b0}};
      sample_ready <= 1'b1;
      tx_bit       <= 1'b0;
      trans_enable <= 1'b0;
      word_out     <= {WORD_W{1'b0}};
      word_valid   <= 1'b0;
      busy         <= 1'b0;
      err_cnt      <= {ERR_CNT_W{1'b0}};
    end else begin
      word_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sample_valid) begin
            tx_shift_r   <= sample_in;
            tx_ref_r     <= sample_in;
            tx_bit       <= sample_in[WORD_W-1];
            trans_enable <= 1'b1;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
            state_r      <= SEND;
          end
        end
        SEND: begin
          // RX_SAMPLE never reaches BIT_DIV-1, so sampling and frame end never collide.
          if (sample_tick_s) begin
            rx_shift_r <= {rx_shift_r[WORD_W-2:0], rx_bit};
          end
          if (frame_end_s) begin
            word_out     <= rx_shift_r;
            word_valid   <= 1'b1;
            trans_enable <= 1'b0;
            tx_bit       <= 1'b0;
            if (rx_shift_r != tx_ref_r) begin
              err_cnt <= err_inc_sat(err_cnt);
            end
            if (GUARD_BITS == 0) begin
              busy         <= 1'b0;
              sample_ready <= 1'b1;
              state_r      <= IDLE;
            end else begin
              state_r <= GUARD;
            end
          end else if (bit_tick_s) begin
            tx_shift_r <= {tx_shift_r[WORD_W-2:0], 1'b0};
            tx_bit     <= tx_shift_r[WORD_W-2];
          end
        end
        GUARD: begin
          if (guard_end_s) begin
            busy         <= 1'b0;
            sample_ready <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_link_ctrl.sv
// Self-checking bench: instance A at default geometry, instance B with
// BIT_DIV=4 and no guard for back-to-back and error-saturation scenarios.
module tb_fsk_link_ctrl;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        a_reset, a_sample_valid, a_sample_ready, a_tx_bit, a_trans_enable;
  logic        a_rx_bit, a_word_valid, a_busy, a_inv, a_d1, a_d2;
  logic [15:0] a_sample_in, a_word_out;
  logic [7:0]  a_err_cnt;
  logic        b_reset, b_sample_valid, b_sample_ready, b_tx_bit, b_trans_enable;
  logic        b_rx_bit, b_word_valid, b_busy, b_inv, b_d1, b_d2;
  logic [15:0] b_sample_in, b_word_out;
  logic [7:0]  b_err_cnt;

  logic [15:0] a_q[$];
  logic [15:0] b_q[$];
  logic [7:0]  a_exp_err, b_exp_err;
  int          n_checks = 0;
  int          n_errors = 0;

  fsk_link_ctrl #(.WORD_W(16), .BIT_DIV(16), .RX_SAMPLE(8), .GUARD_BITS(2)) u_a (
    .sysclk(sysclk), .reset(a_reset), .sample_in(a_sample_in), .sample_valid(a_sample_valid),
    .sample_ready(a_sample_ready), .tx_bit(a_tx_bit), .trans_enable(a_trans_enable),
    .rx_bit(a_rx_bit), .word_out(a_word_out), .word_valid(a_word_valid), .busy(a_busy),
    .err_cnt(a_err_cnt));

  fsk_link_ctrl #(.WORD_W(16), .BIT_DIV(4), .RX_SAMPLE(2), .GUARD_BITS(0)) u_b (
    .sysclk(sysclk), .reset(b_reset), .sample_in(b_sample_in), .sample_valid(b_sample_valid),
    .sample_ready(b_sample_ready), .tx_bit(b_tx_bit), .trans_enable(b_trans_enable),
    .rx_bit(b_rx_bit), .word_out(b_word_out), .word_valid(b_word_valid), .busy(b_busy),
    .err_cnt(b_err_cnt));

  // Channel model: two-cycle delayed loopback or inverted path.
  always @(posedge sysclk) begin
    a_d1 <= a_tx_bit;
    a_d2 <= a_d1;
    b_d1 <= b_tx_bit;
    b_d2 <= b_d1;
  end
  assign a_rx_bit = a_inv ? ~a_tx_bit : a_d2;
  assign b_rx_bit = b_inv ? ~b_tx_bit : b_d2;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_word_a(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (a_word_valid) got = 1'b1;
    end
  endtask

  task automatic wait_word_b(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (b_word_valid) got = 1'b1;
    end
  endtask

  task automatic wait_ready_a(input int budget, output bit got);
    got = a_sample_ready;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (a_sample_ready) got = 1'b1;
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic test_reset();
    a_reset = 1'b0; b_reset = 1'b0;
    a_sample_valid = 1'b1; b_sample_valid = 1'b1;
    a_sample_in = 16'hBEEF; b_sample_in = 16'hBEEF;
    repeat (3) tick();
    n_checks++;
    if ({a_sample_ready, a_tx_bit, a_trans_enable, a_word_valid, a_busy} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctl_a: got %b expected 10000",
               {a_sample_ready, a_tx_bit, a_trans_enable, a_word_valid, a_busy});
    end
    n_checks++;
    if (a_word_out !== 16'h0000 || a_err_cnt !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data_a: word_out %h err_cnt %0d expected 0000 and 0", a_word_out, a_err_cnt);
    end
    n_checks++;
    if ({b_sample_ready, b_tx_bit, b_trans_enable, b_word_valid, b_busy} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctl_b: got %b expected 10000",
               {b_sample_ready, b_tx_bit, b_trans_enable, b_word_valid, b_busy});
    end
    a_sample_valid = 1'b0; b_sample_valid = 1'b0;
    a_reset = 1'b1; b_reset = 1'b1;
    tick();
    n_checks++;
    if (a_trans_enable !== 1'b0 || a_sample_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_no_start: trans_enable %b sample_ready %b expected 0 1", a_trans_enable, a_sample_ready);
    end
  endtask

  task automatic test_loopback();
    int k;
    int en_cnt;
    logic [15:0] exp;
    a_inv = 1'b0;
    a_sample_in = 16'hA5C3; a_sample_valid = 1'b1;
    a_q.push_back(16'hA5C3);
    tick();
    a_sample_valid = 1'b0;
    n_checks++;
    if ({a_trans_enable, a_tx_bit, a_sample_ready, a_busy} !== 4'b1101) begin
      n_errors++;
      $display("FAIL loop_start: got %b expected 1101", {a_trans_enable, a_tx_bit, a_sample_ready, a_busy});
    end
    en_cnt = 1; k = 0;
    while (a_trans_enable && k < 400) begin
      tick();
      k++;
      if (a_trans_enable) en_cnt++;
    end
    n_checks++;
    if (en_cnt != 256 || k != 256) begin
      n_errors++;
      $display("FAIL loop_enable_len: got %0d cycles ending at E0+%0d expected 256 at E0+256", en_cnt, k);
    end
    n_checks++;
    if (a_word_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL loop_word_valid: got %b expected 1", a_word_valid);
    end
    if (a_q.size() > 0) exp = a_q.pop_front();
    else exp = 16'hxxxx;
    n_checks++;
    if (a_word_out !== exp) begin
      n_errors++;
      $display("FAIL loop_word: got %h expected %h", a_word_out, exp);
    end
    n_checks++;
    if (a_err_cnt !== a_exp_err) begin
      n_errors++;
      $display("FAIL loop_err_cnt: got %0d expected %0d", a_err_cnt, a_exp_err);
    end
    tick();
    n_checks++;
    if (a_word_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL loop_pulse_width: word_valid %b expected 0", a_word_valid);
    end
    repeat (30) tick();
    n_checks++;
    if (a_sample_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL loop_ready_early: sample_ready %b at E0+287 expected 0", a_sample_ready);
    end
    tick();
    n_checks++;
    if (a_sample_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL loop_ready: sample_ready %b busy %b at E0+288 expected 1 0", a_sample_ready, a_busy);
    end
  endtask

  task automatic test_error_inject();
    bit got;
    logic [15:0] exp;
    a_inv = 1'b1;
    a_sample_in = 16'h0000; a_sample_valid = 1'b1;
    a_q.push_back(16'hFFFF);
    a_exp_err = sat_inc(a_exp_err);
    tick();
    a_sample_valid = 1'b0;
    wait_word_a(400, got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL err_timeout: word_valid %b expected 1 within 400 cycles", a_word_valid);
    end
    if (a_q.size() > 0) exp = a_q.pop_front();
    else exp = 16'hxxxx;
    n_checks++;
    if (a_word_out !== exp || a_err_cnt !== a_exp_err) begin
      n_errors++;
      $display("FAIL err_inject: word_out %h err_cnt %0d expected %h %0d", a_word_out, a_err_cnt, exp, a_exp_err);
    end
    wait_ready_a(64, got);
    a_inv = 1'b0;
  endtask

  task automatic test_backpressure();
    bit got;
    bit seen;
    logic [15:0] exp;
    logic [15:0] bp_word;
    bp_word = 16'h1234;
    seen = 1'b0;
    a_sample_in = 16'h5A5A; a_sample_valid = 1'b1;
    a_q.push_back(16'h5A5A);
    tick();
    a_sample_valid = 1'b0;
    repeat (9) tick();
    a_sample_in = bp_word; a_sample_valid = 1'b1;
    for (int i = 10; i <= 288; i++) begin
      tick();
      if (a_word_valid) begin
        seen = 1'b1;
        if (a_q.size() > 0) exp = a_q.pop_front();
        else exp = 16'hxxxx;
        n_checks++;
        if (a_word_out !== exp) begin
          n_errors++;
          $display("FAIL bp_first_word: got %h expected %h", a_word_out, exp);
        end
      end
      if (i == 287) begin
        n_checks++;
        if (a_sample_ready !== 1'b0 || a_busy !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_busy: sample_ready %b busy %b at E0+287 expected 0 1", a_sample_ready, a_busy);
        end
      end
    end
    n_checks++;
    if (!seen || a_sample_ready !== 1'b1 || a_trans_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_idle: seen %b sample_ready %b trans_enable %b expected 1 1 0", seen, a_sample_ready, a_trans_enable);
    end
    a_q.push_back(bp_word);
    tick();
    a_sample_valid = 1'b0;
    n_checks++;
    if (a_trans_enable !== 1'b1 || a_sample_ready !== 1'b0 || a_tx_bit !== bp_word[15]) begin
      n_errors++;
      $display("FAIL bp_start: trans_enable %b sample_ready %b tx_bit %b expected 1 0 %b",
               a_trans_enable, a_sample_ready, a_tx_bit, bp_word[15]);
    end
    for (int b = 1; b < 16; b++) begin
      repeat (16) tick();
      n_checks++;
      if (a_tx_bit !== bp_word[15-b]) begin
        n_errors++;
        $display("FAIL bp_tx_bit%0d: got %b expected %b", b, a_tx_bit, bp_word[15-b]);
      end
    end
    wait_word_a(300, got);
    if (a_q.size() > 0) exp = a_q.pop_front();
    else exp = 16'hxxxx;
    n_checks++;
    if (!got || a_word_out !== exp || a_err_cnt !== a_exp_err) begin
      n_errors++;
      $display("FAIL bp_second_word: got_valid %b word_out %h err_cnt %0d expected 1 %h %0d",
               got, a_word_out, a_err_cnt, exp, a_exp_err);
    end
    wait_ready_a(64, got);
  endtask

  task automatic test_reset_mid();
    int pulses;
    a_sample_in = 16'h0F0F; a_sample_valid = 1'b1;
    tick();
    a_sample_valid = 1'b0;
    repeat (99) tick();
    a_reset = 1'b0;
    tick();
    a_exp_err = 8'h00;
    n_checks++;
    if ({a_trans_enable, a_tx_bit, a_word_valid, a_busy, a_sample_ready} !== 5'b00001 || a_err_cnt !== a_exp_err) begin
      n_errors++;
      $display("FAIL mid_reset: ctl %b err_cnt %0d expected 00001 %0d",
               {a_trans_enable, a_tx_bit, a_word_valid, a_busy, a_sample_ready}, a_err_cnt, a_exp_err);
    end
    a_reset = 1'b1;
    pulses = 0;
    repeat (300) begin
      tick();
      if (a_word_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || a_trans_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_no_word: word_valid pulses %0d trans_enable %b expected 0 0", pulses, a_trans_enable);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit got;
    logic [15:0] exp;
    b_inv = 1'b0;
    b_sample_in = 16'hFFFF; b_sample_valid = 1'b1;
    b_q.push_back(16'hFFFF);
    tick();
    b_sample_in = 16'h8001;
    b_q.push_back(16'h8001);
    k = 0;
    do begin
      tick();
      k++;
    end while (b_trans_enable && k < 100);
    n_checks++;
    if (k != 64 || b_word_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_first_end: enable fell at E0+%0d word_valid %b expected 64 1", k, b_word_valid);
    end
    if (b_q.size() > 0) exp = b_q.pop_front();
    else exp = 16'hxxxx;
    n_checks++;
    if (b_word_out !== exp) begin
      n_errors++;
      $display("FAIL b2b_word1: got %h expected %h", b_word_out, exp);
    end
    tick();
    n_checks++;
    if (b_trans_enable !== 1'b1 || b_tx_bit !== 1'b1 || b_sample_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gap: trans_enable %b tx_bit %b sample_ready %b expected 1 1 0",
               b_trans_enable, b_tx_bit, b_sample_ready);
    end
    b_sample_valid = 1'b0;
    wait_word_b(100, got);
    if (b_q.size() > 0) exp = b_q.pop_front();
    else exp = 16'hxxxx;
    n_checks++;
    if (!got || b_word_out !== exp || b_err_cnt !== 8'h00) begin
      n_errors++;
      $display("FAIL b2b_word2: got_valid %b word_out %h err_cnt %0d expected 1 %h 0", got, b_word_out, b_err_cnt, exp);
    end
  endtask

  task automatic test_saturation();
    bit got;
    logic [15:0] exp;
    b_inv = 1'b1;
    b_exp_err = 8'h00;
    b_sample_in = 16'h0000; b_sample_valid = 1'b1;
    for (int f = 0; f < 300; f++) begin
      b_q.push_back(16'hFFFF);
      b_exp_err = sat_inc(b_exp_err);
      wait_word_b(100, got);
      if (b_q.size() > 0) exp = b_q.pop_front();
      else exp = 16'hxxxx;
      n_checks++;
      if (!got || b_word_out !== exp || b_err_cnt !== b_exp_err) begin
        n_errors++;
        $display("FAIL sat_frame%0d: got_valid %b word_out %h err_cnt %0d expected 1 %h %0d",
                 f, got, b_word_out, b_err_cnt, exp, b_exp_err);
      end
    end
    b_sample_valid = 1'b0;
    n_checks++;
    if (b_err_cnt !== 8'hFF) begin
      n_errors++;
      $display("FAIL sat_final: err_cnt %0d expected 255", b_err_cnt);
    end
  endtask

  initial begin
    a_inv = 1'b0; b_inv = 1'b0;
    a_reset = 1'b0; b_reset = 1'b0;
    a_sample_valid = 1'b0; b_sample_valid = 1'b0;
    a_sample_in = 16'h0000; b_sample_in = 16'h0000;
    a_exp_err = 8'h00; b_exp_err = 8'h00;
    test_reset();
    test_loopback();
    test_error_inject();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    n_checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: pending %0d/%0d expected 0/0", a_q.size(), b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsk_link_ctrl.md
Name: fsk_link_ctrl

Overview:
Frame sequencer for the FSK point-to-point link. It accepts one 16-bit ADC sample through a valid/ready handshake and serialises it MSB-first to the FSK modulator, one bit per BIT_DIV sysclk cycles. It drives trans_enable to gate the modulator/demodulator chain and samples the demodulated bitstream mid-bit. It then presents the reassembled word and keeps a loopback error counter. It replaces the free-running parallel/serial converters and enable alert in the top level with one sysclk-domain controller.

Parameters:
WORD_W, 16, bits per frame; MSB first.
BIT_DIV, 16, sysclk cycles per bit period; must be at least 4.
RX_SAMPLE, 8, div_cnt value at which rx_bit is sampled; legal range 0..BIT_DIV-2.
GUARD_BITS, 2, idle bit periods after each frame, with trans_enable low; 0 is legal.

Ports:
sysclk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
sample_in  in  WORD_W  parallel word from ADC.
sample_valid  in  1  sample_in valid.
sample_ready  out  1  controller can accept a word.
tx_bit  out  1  serial bit to modulator control input.
trans_enable  out  1  high for exactly the frame's bit periods.
rx_bit  in  1  demodulated serial bit.
word_out  out  WORD_W  last received word; held until next frame completes.
word_valid  out  1  one-cycle pulse when word_out updates.
busy  out  1  high in SEND or GUARD.
err_cnt  out  8  count of frames where received word differs from sent word; saturates at 255.

Behaviour:
- Reset (reset==0 at an edge) sets: state=IDLE, sample_ready=1, tx_bit=0, trans_enable=0, word_out=0, word_valid=0, busy=0, err_cnt=0, internal counters=0.
- Reset mid-frame aborts the frame: no word_valid, err_cnt cleared.
- States: IDLE, SEND, GUARD.
- IDLE: sample_ready=1. At edge E0 with sample_valid=1:
  - latch sample_in into tx_shift and tx_ref;
  - go to SEND with div_cnt=0, bit_cnt=0;
  - from E0 onward tx_bit=sample_in[WORD_W-1], trans_enable=1, busy=1, sample_ready=0.
- SEND:
  - div_cnt counts 0..BIT_DIV-1 and wraps.
  - At the edge where div_cnt==BIT_DIV-1: shift tx_shift left, tx_bit takes the next bit, bit_cnt++.
  - At the edge where div_cnt==RX_SAMPLE: rx_shift <= {rx_shift[WORD_W-2:0], rx_bit}.
- Frame end, at the edge with div_cnt==BIT_DIV-1 and bit_cnt==WORD_W-1 (E0 + WORD_W*BIT_DIV):
  - word_out<=rx_shift; word_valid=1 for one cycle;
  - trans_enable=0, tx_bit=0;
  - if rx_shift!=tx_ref and err_cnt<255, err_cnt++;
  - next state is GUARD, or IDLE if GUARD_BITS==0.
  - trans_enable is therefore high for exactly WORD_W*BIT_DIV cycles (256 at defaults).
- GUARD:
  - counts GUARD_BITS*BIT_DIV cycles, then goes to IDLE.
  - sample_ready rises at E0 + (WORD_W+GUARD_BITS)*BIT_DIV (288 at defaults).
- sample_valid while busy is ignored and the word is not consumed; the requester holds it until ready.
- A new frame may start on the very first IDLE cycle, giving back-to-back frames.
- tx_bit and trans_enable are registered outputs: no combinational path from sample_valid.
- word_valid and frame completion in the same cycle are one event: err_cnt updates at the same edge word_out updates.

Decomposition:
- Shared package fsk_pkg:
  - state enum (IDLE, SEND, GUARD);
  - default constants FSK_WORD_W=16, FSK_BIT_DIV=16;
  - ERR_CNT_W=8.
- One sub-module, fsk_bit_timer:
  - contains the div_cnt/bit_cnt pair;
  - outputs bit_tick (div_cnt==BIT_DIV-1), sample_tick (div_cnt==RX_SAMPLE) and last_bit;
  - inputs are clear and run.
- The FSM and shift registers stay in fsk_link_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles with sample_valid=1 -> all outputs at reset values; sample_ready=1; no frame starts.
- Loopback: rx_bit=tx_bit delayed 2 cycles, send 16'hA5C3 -> trans_enable high exactly 256 cycles; word_valid pulse at E0+256 with word_out=16'hA5C3; err_cnt=0; sample_ready back at E0+288.
- Error injection: rx_bit=~tx_bit, send 16'h0000 -> word_out=16'hFFFF, err_cnt=1. Repeat 300 frames -> err_cnt saturates at 255.
- Busy backpressure: assert sample_valid with 16'h1234 at E0+10 during a frame -> not accepted; frame starts on the first IDLE cycle (E0+288); tx_bit sequence is MSB-first 0,0,0,1,0,0,1,0...
- Reset mid-frame: pulse reset=0 at E0+100 -> trans_enable=0 next cycle; no word_valid; err_cnt=0; sample_ready=1.
- GUARD_BITS=0, BIT_DIV=4: two queued words 16'hFFFF and 16'h8001 -> second frame starts at E0+64; trans_enable low for exactly 1 cycle between frames; both words received correctly.
